// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared types and constants for the tile-RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int unsigned TILE_SHIFT     = 3;
    localparam int unsigned TILE_COLS      = 80;
    localparam int          DEFAULT_DATA_W = 4;
    localparam int          DEFAULT_ADDR_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DISP  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    // Linear tile index of a pixel; x selects the tile row, y the tile column.
    function automatic int unsigned tile_index(input logic [9:0]  x,
                                               input logic [9:0]  y,
                                               input int unsigned cols);
        int unsigned xt;
        int unsigned yt;
        xt = 32'(x >> TILE_SHIFT);
        yt = 32'(y >> TILE_SHIFT);
        return xt * cols + yt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_if
// Description : Display, write-request and tile-RAM signals of vram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if #(
    parameter int DATA_W = vram_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = vram_pkg::DEFAULT_ADDR_W
);
    logic              i_show_en;
    logic [9:0]        i_x_cord;
    logic [9:0]        i_y_cord;
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_gnt;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_pix_valid;
    logic [DATA_W-1:0] o_pix_data;
    logic              o_busy;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0]       o_stall_cnt;
`endif

    modport slave (
        input  i_show_en, i_x_cord, i_y_cord,
        input  i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_gnt, o_mem_addr, o_mem_we, o_mem_wdata,
`ifdef VRAM_ARB_STATS_EN
        output o_stall_cnt,
`endif
        output o_pix_valid, o_pix_data, o_busy
    );

    modport master (
        output i_show_en, i_x_cord, i_y_cord,
        output i_wr_req, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_gnt, o_mem_addr, o_mem_we, o_mem_wdata,
`ifdef VRAM_ARB_STATS_EN
        input  o_stall_cnt,
`endif
        input  o_pix_valid, o_pix_data, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/vram_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vram_wr_fifo
// Description : Posted-write buffer; first-word-fall-through head output.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_wr_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         head_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = r_mem[r_rd_ptr];
    assign full      = (r_level == LVL_W'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Tile-RAM arbiter; display reads win, game writes are posted
//               and drained during blanking. Optional macro VRAM_ARB_STATS_EN
//               adds a saturating write-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int DATA_W     = vram_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W     = vram_pkg::DEFAULT_ADDR_W,
    parameter int TILE_COLS  = vram_pkg::TILE_COLS,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic     i_clk_25M,
    input  wire logic     i_rst_n,
    vram_arbiter_if.slave bus
);
    import vram_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_t               r_state;
    arb_state_t               w_state_nxt;
    logic                     w_wr_gnt;
    logic                     w_pop;
    logic                     w_last_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [LVL_W-1:0]         w_level;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [ADDR_W-1:0]        w_disp_addr;
    logic                     w_oor;
    logic                     r_vld1;
    logic                     r_oor1;
    logic                     r_vld2;
    logic [DATA_W-1:0]        r_pix2;

    assign w_wr_gnt    = bus.i_wr_req && !w_full && i_rst_n;
    assign w_pop       = !bus.i_show_en && !w_empty;
    assign w_last_pop  = w_pop && !w_wr_gnt && (w_level == LVL_W'(1));
    assign w_disp_addr = ADDR_W'(tile_index(bus.i_x_cord, bus.i_y_cord, TILE_COLS));
    assign w_oor       = (bus.i_x_cord > 10'd479) || (bus.i_y_cord > 10'd639);

    vram_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk_25M),
        .rst_n     (i_rst_n),
        .push      (w_wr_gnt),
        .push_data ({bus.i_wr_addr, bus.i_wr_data}),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (w_level)
    );

    assign bus.o_wr_gnt    = w_wr_gnt;
    assign bus.o_mem_we    = w_pop;
    assign bus.o_mem_addr  = w_pop ? w_head[ADDR_W+DATA_W-1:DATA_W] : w_disp_addr;
    assign bus.o_mem_wdata = w_pop ? w_head[DATA_W-1:0] : '0;
    // The first drain cycle still shows the previous state, so it counts as busy.
    assign bus.o_busy      = (r_state == ST_DRAIN) || w_pop;

    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_show_en) begin
            w_state_nxt = ST_DISP;
        end else begin
            case (r_state)
                ST_DISP, ST_IDLE: w_state_nxt = (!w_empty && !w_last_pop) ? ST_DRAIN : ST_IDLE;
                ST_DRAIN:         w_state_nxt = (w_empty || w_last_pop) ? ST_IDLE : ST_DRAIN;
                default:          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Two-stage pixel pipe: address cycle, RAM read cycle, then output register.
    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld1 <= 1'b0;
            r_oor1 <= 1'b0;
            r_vld2 <= 1'b0;
            r_pix2 <= '0;
        end else begin
            r_vld1 <= bus.i_show_en;
            r_oor1 <= bus.i_show_en && w_oor;
            r_vld2 <= r_vld1;
            r_pix2 <= (r_vld1 && !r_oor1) ? bus.i_mem_rdata : '0;
        end
    end

    assign bus.o_pix_valid = r_vld2;
    assign bus.o_pix_data  = r_pix2;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n)                                                  r_stall_cnt <= '0;
        else if (bus.i_wr_req && w_full && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign bus.o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 13;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_mis;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    vram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vram_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .TILE_COLS  (80),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk_25M (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, synchronous read with one cycle of latency.
    always @(posedge clk) begin
        if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
        bus.i_mem_rdata <= ram[bus.o_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_we"},   32'(bus.o_mem_we), 1);
        check({tag, "_addr"}, 32'(bus.o_mem_addr), addr);
        check({tag, "_data"}, 32'(bus.o_mem_wdata), data);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int addr, input int data, input logic exp_gnt);
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = ADDR_W'(addr);
        bus.i_wr_data = DATA_W'(data);
        #1;
        check(tag, 32'(bus.o_wr_gnt), 32'(exp_gnt));
        step();
        bus.i_wr_req = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        ram[82]   = 4'hA;
        ram[997]  = 4'h5;
        ram[4800] = 4'hF;
        ram[160]  = 4'h3;
        rst_n         = 1'b0;
        bus.i_show_en = 1'b0;
        bus.i_x_cord  = '0;
        bus.i_y_cord  = '0;
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = '0;
        bus.i_wr_data = '0;
        bus.i_mem_rdata = '0;
        #1;
        step();
        step();

        // Reset state, with a write request held during reset
        check("rst_gnt",  32'(bus.o_wr_gnt), 0);
        check("rst_we",   32'(bus.o_mem_we), 0);
        check("rst_pixv", 32'(bus.o_pix_valid), 0);
        check("rst_pixd", 32'(bus.o_pix_data), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
`ifdef VRAM_ARB_STATS_EN
        check("rst_stall", 32'(bus.o_stall_cnt), 0);
`endif
        bus.i_wr_req = 1'b0;
        rst_n = 1'b1;
        step();

        // Display reads: address, two-cycle latency, out-of-range blanking
        bus.i_show_en = 1'b1;
        bus.i_x_cord = 10'd8;
        bus.i_y_cord = 10'd16;
        #1;
        check("disp_addr82", 32'(bus.o_mem_addr), 82);
        check("disp_we0",    32'(bus.o_mem_we), 0);
        step();
        check("lat1_pixv", 32'(bus.o_pix_valid), 0);
        step();
        check("lat2_pixv", 32'(bus.o_pix_valid), 1);
        check("pix82",     32'(bus.o_pix_data), 32'hA);

        bus.i_x_cord = 10'd100;
        bus.i_y_cord = 10'd300;
        #1;
        check("disp_addr997", 32'(bus.o_mem_addr), 997);
        step();
        step();
        check("pix997", 32'(bus.o_pix_data), 32'h5);

        bus.i_x_cord = 10'd480;
        bus.i_y_cord = 10'd0;
        #1;
        check("disp_addr4800", 32'(bus.o_mem_addr), 4800);
        step();
        step();
        check("oorx_pixv", 32'(bus.o_pix_valid), 1);
        check("oorx_pixd", 32'(bus.o_pix_data), 0);

        bus.i_x_cord = 10'd8;
        bus.i_y_cord = 10'd640;
        step();
        step();
        check("oory_pixd", 32'(bus.o_pix_data), 0);

        bus.i_show_en = 1'b0;
        step();
        step();
        check("blank_pixv", 32'(bus.o_pix_valid), 0);
        check("blank_pixd", 32'(bus.o_pix_data), 0);
        check("blank_we",   32'(bus.o_mem_we), 0);

        // Three queued writes drain in order at blanking
        bus.i_show_en = 1'b1;
        bus.i_x_cord = '0;
        bus.i_y_cord = '0;
        for (int i = 0; i < 3; i++) push("q3_gnt", 200 + i, i + 1, 1'b1);
        bus.i_show_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_wr("drain3", 200 + i, i + 1);
            check("drain3_busy", 32'(bus.o_busy), 1);
            step();
        end
        #1;
        check("drain3_done_we",   32'(bus.o_mem_we), 0);
        check("drain3_done_busy", 32'(bus.o_busy), 0);
        check("ram200", 32'(ram[200]), 1);
        check("ram202", 32'(ram[202]), 3);

        // Display resumes after one of three drained
        bus.i_show_en = 1'b1;
        for (int i = 0; i < 3; i++) push("q3b_gnt", 300 + i, i + 4, 1'b1);
        bus.i_show_en = 1'b0;
        #1;
        check_wr("intr_first", 300, 4);
        step();
        bus.i_show_en = 1'b1;
        #1;
        check("intr_we0",   32'(bus.o_mem_we), 0);
        check("intr_busy",  32'(bus.o_busy), 1);
        check("intr_addr",  32'(bus.o_mem_addr), 0);
        step();
        check("intr_disp_busy", 32'(bus.o_busy), 0);
        check("intr_disp_we",   32'(bus.o_mem_we), 0);
        step();
        bus.i_show_en = 1'b0;
        #1;
        check_wr("resume301", 301, 5);
        step();
        check_wr("resume302", 302, 6);
        step();
        check("resume_done_we", 32'(bus.o_mem_we), 0);
        check("ram301", 32'(ram[301]), 5);

        // Five back-to-back requests into a four-deep buffer
        bus.i_show_en = 1'b1;
        for (int i = 0; i < 5; i++) push("burst_gnt", 400 + i, 8 + i, (i < 4));
`ifdef VRAM_ARB_STATS_EN
        check("stall_cnt1", 32'(bus.o_stall_cnt), 1);
`endif

        // Push against pop with the buffer full: refused, then granted at level 3
        bus.i_show_en = 1'b0;
        bus.i_wr_req  = 1'b1;
        bus.i_wr_addr = ADDR_W'(500);
        bus.i_wr_data = 4'h9;
        #1;
        check("full_pp_gnt", 32'(bus.o_wr_gnt), 0);
        check_wr("full_pp_pop", 400, 8);
        step();
        bus.i_wr_addr = ADDR_W'(501);
        bus.i_wr_data = 4'hA;
        #1;
        check("lvl3_gnt", 32'(bus.o_wr_gnt), 1);
        check_wr("lvl3_pop", 401, 9);
        step();
        bus.i_wr_req = 1'b0;
        check_wr("tail402", 402, 10);
        step();
        check_wr("tail403", 403, 11);
        step();
        check_wr("tail501", 501, 32'hA);
        step();
        check("tail_done_we",   32'(bus.o_mem_we), 0);
        check("tail_done_busy", 32'(bus.o_busy), 0);
        check("ram404_never", 32'(ram[404]), 0);
        check("ram500_never", 32'(ram[500]), 0);
`ifdef VRAM_ARB_STATS_EN
        check("stall_cnt2", 32'(bus.o_stall_cnt), 2);
`endif

        // Reset with two entries pending discards them
        bus.i_show_en = 1'b1;
        push("pre_rst_gnt", 600, 7, 1'b1);
        push("pre_rst_gnt", 601, 8, 1'b1);
        rst_n = 1'b0;
        bus.i_show_en = 1'b0;
        #1;
        check("inrst_we",   32'(bus.o_mem_we), 0);
        check("inrst_busy", 32'(bus.o_busy), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("postrst_we", 32'(bus.o_mem_we), 0);
            step();
        end
        check("ram600_discarded", 32'(ram[600]), 0);
        check("ram601_discarded", 32'(ram[601]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter DATA_W, default 4, meaning tile-code width in bits.
REQ-002 Parameter ADDR_W, default 13, meaning tile-RAM address width.
REQ-003 Parameter TILE_COLS, default 80, meaning tiles per display row (640/8).
REQ-004 Parameter FIFO_DEPTH, default 4, meaning posted-write buffer entries (power of 2, at least 2).
REQ-005 Clock and reset: one clock, i_clk_25M; reset i_rst_n, asynchronous, active-low.
REQ-006 Port i_clk_25M  input  1  pixel clock.
REQ-007 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-008 Port i_show_en  input  1  display-active flag from the VGA timing block.
REQ-009 Port i_x_cord  input  10  vertical pixel coordinate, 0..479.
REQ-010 Port i_y_cord  input  10  horizontal pixel coordinate, 0..639.
REQ-011 Port i_wr_req / i_wr_addr / i_wr_data  input  1 / ADDR_W / DATA_W  game-logic tile write request.
REQ-012 Port o_wr_gnt  output  1  write accepted this cycle.
REQ-013 Port o_mem_addr / o_mem_we / o_mem_wdata  output  ADDR_W / 1 / DATA_W  single-port tile RAM, synchronous read, 1-cycle latency.
REQ-014 Port i_mem_rdata  input  DATA_W  RAM read data.
REQ-015 Port o_pix_valid / o_pix_data  output  1 / DATA_W  tile code for the renderer.
REQ-016 Port o_busy  output  1  high while in ST_DRAIN.

Function
REQ-017 Display read has absolute priority: when i_show_en=1, the block SHALL drive o_mem_addr = (i_x_cord>>3)*TILE_COLS + (i_y_cord>>3) and o_mem_we=0.
REQ-018 o_pix_valid and o_pix_data SHALL follow i_show_en and the coordinates by exactly 2 cycles; o_pix_data=0 whenever the delayed show_en is 0.
REQ-019 With i_show_en=1 and i_x_cord>479 or i_y_cord>639, the block SHALL force the delayed o_pix_data to 0.
REQ-020 Writes SHALL be posted into the FIFO: o_wr_gnt = i_wr_req && !full; an entry is pushed when o_wr_gnt=1, in any display phase.
REQ-021 When i_show_en=0 and the FIFO is not empty, the block SHALL drive o_mem_we=1 with the head entry's address and data, and pop the head in that same cycle.
REQ-022 A push and a pop in the same cycle SHALL both take effect with the level unchanged; o_wr_gnt uses the pre-pop full flag.
REQ-023 FSM states ST_DISP, ST_IDLE and ST_DRAIN are registered:
- any state -> ST_DISP when i_show_en=1.
- ST_DISP or ST_IDLE -> ST_DRAIN when i_show_en=0 and the FIFO is not empty.
- ST_DISP -> ST_IDLE when i_show_en=0 and the FIFO is empty.
- ST_DRAIN -> ST_IDLE when the last entry is popped.
REQ-024 When i_show_en rises mid-drain, the block SHALL stall the head entry (not lose it) and resume at the next blanking.
REQ-025 Writes SHALL be drained in order, exactly once each.

Reset
REQ-026 On i_rst_n=0 the block SHALL enter ST_IDLE, empty the FIFO, and set o_wr_gnt, o_mem_we, o_pix_valid, o_pix_data, o_busy and both delay stages to 0.
REQ-027 Reset asserted mid-drain SHALL discard all pending entries; no write occurs while i_rst_n=0.

Configuration
REQ-028 Macro VRAM_ARB_STATS_EN:
- Defined: adds output o_stall_cnt [15:0], which counts cycles with i_wr_req=1 and full. It saturates at 16'hFFFF and is cleared by reset.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Structure
REQ-029 A shared package vram_pkg SHALL hold the state enum type, TILE_SHIFT=3, TILE_COLS and the default DATA_W/ADDR_W values.
REQ-030 The posted-write buffer SHALL be a sub-module vram_wr_fifo with push/pop/full/empty ports.

Verification
REQ-031 Drive i_show_en=1 at x=8, y=16 -> o_mem_addr=82, o_mem_we=0; after 2 cycles o_pix_valid=1 and o_pix_data equals the RAM content at address 82.
REQ-032 Send 5 back-to-back requests during display with FIFO_DEPTH=4 -> o_wr_gnt=1 for 4 cycles then 0; with the macro defined, o_stall_cnt=1.
REQ-033 Let i_show_en fall with 3 entries queued -> o_mem_we=1 for 3 consecutive cycles in push order; o_busy=1 for those 3 cycles, then ST_IDLE.
REQ-034 Raise i_show_en after 1 of 3 drained -> o_mem_we=0 immediately; the remaining 2 entries are written at the next blanking.
REQ-035 Issue a simultaneous push and pop with the FIFO full -> no grant; the next cycle, with the FIFO at level 3, o_wr_gnt=1.
REQ-036 Assert reset with 2 entries queued -> the FIFO is empty, and no write occurs after release with i_show_en=0.
